// File: rtl/bram_stream_reader_if.sv
// bram_stream_reader_if: command, BRAM port-B and output stream signals of the reader.
interface bram_stream_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  length;
  logic                  busy;
  logic                  done;
  logic                  enb;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [DATA_WIDTH-1:0] doutb;
  logic                  validb;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;
  modport master (
    input  start, base_addr, length, doutb, validb, m_ready,
    output busy, done, enb, addrb, m_data, m_valid, m_last
  );
  modport slave (
    output start, base_addr, length, doutb, validb, m_ready,
    input  busy, done, enb, addrb, m_data, m_valid, m_last
  );
endinterface

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: issues sequential port-B reads and streams the words out through a 2-entry skid FIFO.
module bram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input logic                  i_clk,
  input logic                  i_rstn,
  bram_stream_reader_if.master io_bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_issue_cnt, r_pop_cnt;
  logic                  r_inflight, r_done;
  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wptr, r_rptr;
  logic [1:0]            r_cnt;
  logic                  w_accept, w_zero, w_push, w_pop, w_enb, w_last, w_fin;
  logic [2:0]            w_credit;
  assign w_accept = r_state == IDLE && io_bus.start && io_bus.length != '0;
  assign w_zero   = r_state == IDLE && io_bus.start && io_bus.length == '0;
  assign w_push   = io_bus.validb && r_inflight;
  assign w_pop    = r_cnt != 2'd0 && io_bus.m_ready;
  assign w_last   = r_cnt != 2'd0 && r_pop_cnt == LEN_WIDTH'(1);
  assign w_fin    = r_state == DRAIN && w_pop && w_last;
  // FIFO occupancy plus the read in flight, net of this cycle's pop, bounds issue so the FIFO cannot overflow
  assign w_credit = {1'b0, r_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_enb    = r_state == RUN && r_issue_cnt != '0 && w_credit < 3'd2;
  assign io_bus.busy    = r_state != IDLE;
  assign io_bus.done    = r_done;
  assign io_bus.enb     = w_enb;
  assign io_bus.addrb   = r_addr;
  assign io_bus.m_valid = r_cnt != 2'd0;
  assign io_bus.m_data  = r_mem[r_rptr];
  assign io_bus.m_last  = w_last;
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = RUN;
    if (r_state == RUN && w_enb && r_issue_cnt == LEN_WIDTH'(1)) w_next = DRAIN;
    if (w_fin) w_next = IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      r_addr      <= '0;
      r_issue_cnt <= '0;
      r_pop_cnt   <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
      r_mem[0]    <= '0;
      r_mem[1]    <= '0;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_cnt       <= 2'd0;
    end else begin
      r_inflight <= w_enb;
      r_done     <= w_zero || w_fin;
      if (w_accept) begin
        r_addr      <= io_bus.base_addr;
        r_issue_cnt <= io_bus.length;
        r_pop_cnt   <= io_bus.length;
      end else begin
        if (w_enb) begin
          r_addr      <= r_addr == ADDR_WIDTH'(DEPTH - 1) ? '0 : r_addr + 1'b1;
          r_issue_cnt <= r_issue_cnt - 1'b1;
        end
        if (w_pop) r_pop_cnt <= r_pop_cnt - 1'b1;
      end
      if (w_push) begin
        r_mem[r_wptr] <= io_bus.doutb;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rstn) !(w_push && r_cnt == 2'd2 && !w_pop));
endmodule
